lcd_bus_arbiter: RTL and testbench
==================================

Name: lcd_bus_arbiter

Overview:
- Shares one 4-bit HD44780-style LCD bus (rs, en, D4–D7) between NUM_REQ byte-level requesters, e.g. the init/message sequencer and a status writer.
- Each requester submits {rs, byte} over a valid/ready handshake.
- Arbitration is round-robin. A lock lets one requester keep the bus for a multi-byte burst, e.g. set-cursor followed by characters.
- The block generates the nibble timing and the post-byte settle delay, so requesters never count delays themselves.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
EN_CYCLES, 100, clk cycles lcd_en is high per nibble
NIBBLE_GAP, 100, clk cycles lcd_en is low between high and low nibble
CMD_DELAY, 50, settle cycles after a normal byte (≥40 us at 1 MHz)
LONG_DELAY, 2000, settle cycles after clear/home (≥1.52 ms at 1 MHz)
CNT_W, 16, delay counter width; must hold max(EN_CYCLES, NIBBLE_GAP, LONG_DELAY)

Ports:
clk  in  1  system clock (1 MHz nominal)
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_rs  in  NUM_REQ  per-requester register select (0 = command, 1 = data)
req_data  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_lock  in  NUM_REQ  requester i asks to keep the bus after this byte
req_ready  out  NUM_REQ  one-cycle accept pulse per requester
grant_id  out  2  index of the last accepted requester
busy  out  1  high whenever state != IDLE
lcd_rs  out  1  LCD register select
lcd_en  out  1  LCD enable
lcd_data  out  4  LCD D4–D7

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, counter=0, rr_ptr=0, lock_owner=none.
  - Outputs: lcd_rs=0, lcd_en=0, lcd_data=0, req_ready=0, grant_id=0, busy=0.
  - Reset mid-transfer aborts immediately. lcd_en drops asynchronously and the byte is lost.
- States: IDLE, HI_SET, HI_EN, HI_GAP, LO_SET, LO_EN, SETTLE.
- IDLE, with no lock owner:
  - Search starts at rr_ptr and wraps; the first i with req_valid[i]=1 is granted.
  - Grant: req_ready[i]=1 this cycle. {rs, byte, lock} are captured. grant_id<=i, rr_ptr<=(i+1) mod NUM_REQ. Next state is HI_SET.
  - With no valid requester, stay in IDLE.
- IDLE, with a lock owner j:
  - Only j can be granted; other requesters wait regardless of rr_ptr.
  - If req_valid[j]=0 and req_lock[j]=0, the lock is released that cycle and no grant is made that cycle.
- Lock ownership:
  - A byte captured with lock=1 sets lock_owner=i.
  - A byte captured with lock=0 clears lock_owner.
- HI_SET (1 cycle): lcd_rs=captured rs, lcd_data=byte[7:4], lcd_en=0. This is the address setup cycle.
- HI_EN: lcd_en=1 for exactly EN_CYCLES cycles.
- HI_GAP: lcd_en=0 for exactly NIBBLE_GAP cycles.
- LO_SET (1 cycle): lcd_data=byte[3:0], lcd_en=0.
- LO_EN: lcd_en=1 for exactly EN_CYCLES cycles.
- SETTLE:
  - lcd_en=0 for exactly the settle delay, then return to IDLE.
  - The delay is LONG_DELAY if rs=0 and byte ∈ {0x01, 0x02, 0x03}; otherwise CMD_DELAY.
- Latency: if a byte is accepted at cycle T, the next accept is no earlier than T+1+(2+2·EN_CYCLES+NIBBLE_GAP+delay).
- lcd_rs and lcd_data hold their last values in IDLE. lcd_en is 0 in every state except HI_EN and LO_EN.
- Handshake rules:
  - Captured inputs are frozen; requester changes after acceptance have no effect on the byte in flight.
  - A requester must hold valid/rs/data stable until it sees req_ready.
  - At most one req_ready bit is high in any cycle.
- Counter reaches terminal value at count-1 and resets to 0 on every state change. No counter wrap is possible given the CNT_W constraint.

Test Plan:
- Bench parameters for all cases: EN_CYCLES=4, NIBBLE_GAP=2, CMD_DELAY=3, LONG_DELAY=10.
- Reset then single write: req0 rs=1, data=0x55. Require req_ready[0] at T; lcd_data=5 at T+1; lcd_en high T+2..T+5, low T+6..T+7; lcd_data=5 at T+8; en high T+9..T+12; busy falls at T+16.
- Long delay: req0 rs=0, data=0x01. Require SETTLE=10 cycles, busy low 23 cycles after accept. Repeat with rs=1, data=0x01: SETTLE=3.
- Round-robin: req0 and req1 valid continuously from reset. Grant order 0,1,0,1; grant_id matches; never two ready bits in one cycle.
- Lock burst: req1 sends 0x80 lock=1, 0x48 lock=1, 0x49 lock=0 while req0 is valid throughout. All three req1 bytes go out before any req0 grant. Then release: req1 drops valid and lock while owner; req0 is granted on the following IDLE cycle.
- Reset mid HI_EN: assert rst. lcd_en=0 asynchronously, busy=0; the next write after reset completes with normal timing.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter sharing one 4-bit HD44780 bus between byte requesters.
// It generates the nibble strobes and the post-byte settle delay for each accepted byte.
module lcd_bus_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned EN_CYCLES  = 100,
    parameter int unsigned NIBBLE_GAP = 100,
    parameter int unsigned CMD_DELAY  = 50,
    parameter int unsigned LONG_DELAY = 2000,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rs,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [1:0]           grant_id,
    output logic                 busy,
    output logic                 lcd_rs,
    output logic                 lcd_en,
    output logic [3:0]           lcd_data
);

    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NIBBLE_GAP - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_DELAY - 1);
    localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(LONG_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE, HI_SET, HI_EN, HI_GAP, LO_SET, LO_EN, SETTLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_rr_ptr;
    logic             r_lock_vld;
    logic [1:0]       r_lock_id;
    logic [3:0]       r_lo_nib;
    logic             r_long;

    logic             w_grant;
    logic             w_release;
    logic [1:0]       w_gidx;
    logic [31:0]      w_idx;
    logic             w_rs;
    logic             w_lock;
    logic [7:0]       w_byte;
    logic [1:0]       w_nptr;
    logic             w_clear_home;
    logic [CNT_W-1:0] w_settle_last;

    // Arbitration: honour the lock owner, otherwise first valid requester from rr_ptr.
    always_comb begin
        w_grant   = 1'b0;
        w_release = 1'b0;
        w_gidx    = '0;
        w_idx     = '0;
        if (r_state == IDLE && !rst) begin
            if (r_lock_vld) begin
                if (|(req_valid & (NUM_REQ'(1) << r_lock_id))) begin
                    w_grant = 1'b1;
                    w_gidx  = r_lock_id;
                end else if (!(|(req_lock & (NUM_REQ'(1) << r_lock_id)))) begin
                    w_release = 1'b1;
                end
            end else begin
                // Descending scan so the candidate closest to rr_ptr wins.
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    w_idx = 32'(r_rr_ptr) + 32'(k);
                    if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
                    if (|(req_valid & (NUM_REQ'(1) << w_idx))) begin
                        w_grant = 1'b1;
                        w_gidx  = 2'(w_idx);
                    end
                end
            end
        end
    end

    assign w_rs          = |(req_rs & (NUM_REQ'(1) << w_gidx));
    assign w_lock        = |(req_lock & (NUM_REQ'(1) << w_gidx));
    assign w_byte        = 8'(req_data >> (8 * 32'(w_gidx)));
    assign w_nptr        = (32'(w_gidx) + 32'd1 >= NUM_REQ) ? 2'd0 : w_gidx + 2'd1;
    assign w_clear_home  = !w_rs && (w_byte == 8'h01 || w_byte == 8'h02 || w_byte == 8'h03);
    assign w_settle_last = r_long ? LONG_LAST : CMD_LAST;
    assign req_ready     = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rr_ptr   <= '0;
            r_lock_vld <= 1'b0;
            r_lock_id  <= '0;
            r_lo_nib   <= '0;
            r_long     <= 1'b0;
            grant_id   <= '0;
            busy       <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            lcd_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_release) r_lock_vld <= 1'b0;
                    if (w_grant) begin
                        r_state    <= HI_SET;
                        r_cnt      <= '0;
                        r_lo_nib   <= w_byte[3:0];
                        r_long     <= w_clear_home;
                        r_lock_vld <= w_lock;
                        r_lock_id  <= w_gidx;
                        r_rr_ptr   <= w_nptr;
                        grant_id   <= w_gidx;
                        busy       <= 1'b1;
                        lcd_rs     <= w_rs;
                        lcd_data   <= w_byte[7:4];
                    end
                end
                HI_SET: begin
                    r_state <= HI_EN;
                    r_cnt   <= '0;
                    lcd_en  <= 1'b1;
                end
                HI_EN: begin
                    if (r_cnt == EN_LAST) begin
                        r_state <= HI_GAP;
                        r_cnt   <= '0;
                        lcd_en  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                HI_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state  <= LO_SET;
                        r_cnt    <= '0;
                        lcd_data <= r_lo_nib;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                LO_SET: begin
                    r_state <= LO_EN;
                    r_cnt   <= '0;
                    lcd_en  <= 1'b1;
                end
                LO_EN: begin
                    if (r_cnt == EN_LAST) begin
                        r_state <= SETTLE;
                        r_cnt   <= '0;
                        lcd_en  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (r_cnt == w_settle_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    lcd_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios plus random traffic, checked each cycle
// against a timeline model built from accept times and nibble/settle offsets.
module tb_lcd_bus_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned EN    = 4;
    localparam int unsigned GAP   = 2;
    localparam int unsigned CMDD  = 3;
    localparam int unsigned LONGD = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_rs = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_lock = '0;
    logic [1:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        lcd_rs;
    logic        lcd_en;
    logic [3:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_bus_arbiter #(
        .NUM_REQ(NREQ), .EN_CYCLES(EN), .NIBBLE_GAP(GAP),
        .CMD_DELAY(CMDD), .LONG_DELAY(LONGD), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data), .req_lock(req_lock),
        .req_ready(req_ready), .grant_id(grant_id), .busy(busy),
        .lcd_rs(lcd_rs), .lcd_en(lcd_en), .lcd_data(lcd_data)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Requester-side state: the item being offered, queued directed items, lock hold time.
    logic [1:0] p_valid, p_rs, p_lock, ld;
    logic [7:0] p_data [2];
    int         keep [2];
    logic [9:0] q0 [$];
    logic [9:0] q1 [$];

    // Reference model: one accepted byte at a time, outputs derived from offsets.
    int         m_t, m_tot, m_end, m_ptr, m_owner;
    logic [3:0] m_hi, m_lo, m_data;
    logic       m_rsc, m_rs;
    logic [1:0] m_gidn, m_gid;

    int   gq [$];
    int   aq [$];
    int   fq [$];
    int   acc_cyc, fall_cyc;
    logic prev_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_t = -100000; m_tot = 0; m_end = 0; m_ptr = 0; m_owner = -1;
        m_hi = '0; m_lo = '0; m_data = '0; m_rsc = 1'b0; m_rs = 1'b0;
        m_gidn = '0; m_gid = '0;
        p_valid = '0; p_rs = '0; p_lock = '0; ld = '0;
        keep[0] = 0; keep[1] = 0;
        q0.delete(); q1.delete();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic do_reset();
        #1 rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rst_busy",  busy,      0);
        chk("rst_en",    lcd_en,    0);
        chk("rst_data",  lcd_data,  0);
        chk("rst_rs",    lcd_rs,    0);
        chk("rst_gid",   grant_id,  0);
        chk("rst_ready", req_ready, 0);
        req_valid = '0; req_rs = '0; req_data = '0; req_lock = '0;
        model_reset();
        prev_busy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cycle(input int refill);
        int         o, g, j, d;
        logic [9:0] it;
        logic [15:0] dd;
        logic       eb, een;
        logic [1:0] er;
        @(posedge clk);
        #1;
        cyc++;
        dd = '0;
        for (int i = 0; i < 2; i++) begin
            if (!p_valid[i]) begin
                if (i == 0 && q0.size() > 0) begin
                    it = q0.pop_front(); p_valid[i] = 1'b1;
                    p_rs[i] = it[9]; p_lock[i] = it[8]; p_data[i] = it[7:0];
                end else if (i == 1 && q1.size() > 0) begin
                    it = q1.pop_front(); p_valid[i] = 1'b1;
                    p_rs[i] = it[9]; p_lock[i] = it[8]; p_data[i] = it[7:0];
                end else if (32'($urandom_range(99)) < refill) begin
                    p_valid[i] = 1'b1;
                    p_rs[i]    = 1'($urandom_range(1));
                    p_lock[i]  = ($urandom_range(3) == 0);
                    p_data[i]  = ($urandom_range(2) == 0) ? 8'($urandom_range(4)) : 8'($urandom);
                end
            end
            ld[i] = p_valid[i] ? p_lock[i] : (keep[i] > 0);
            if (!p_valid[i] && keep[i] > 0) keep[i]--;
            dd[8*i +: 8] = p_valid[i] ? p_data[i] : 8'($urandom);
        end
        req_valid = p_valid;
        req_rs    = p_rs & p_valid;
        req_lock  = ld;
        req_data  = dd;

        o = cyc - m_t;
        if (o == 1) begin m_data = m_hi; m_rs = m_rsc; m_gid = m_gidn; end
        if (o == 2 + int'(EN) + int'(GAP)) m_data = m_lo;
        eb  = (o >= 1 && o < m_tot);
        een = (o >= 2 && o < 2 + int'(EN)) ||
              (o >= 3 + int'(EN) + int'(GAP) && o < 3 + 2 * int'(EN) + int'(GAP));

        g = -1;
        if (cyc >= m_end) begin
            if (m_owner >= 0) begin
                if (p_valid[m_owner]) g = m_owner;
                else if (!ld[m_owner]) m_owner = -1;
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    j = (m_ptr + k) % int'(NREQ);
                    if (p_valid[j]) g = j;
                end
            end
        end
        er = (g >= 0) ? 2'(1 << g) : 2'b00;

        #1;
        chk("busy",      busy,      eb);
        chk("lcd_en",    lcd_en,    een);
        chk("lcd_data",  lcd_data,  m_data);
        chk("lcd_rs",    lcd_rs,    m_rs);
        chk("grant_id",  grant_id,  m_gid);
        chk("req_ready", req_ready, er);
        chk("one_hot",   32'($countones(req_ready) <= 1), 1);

        if (req_ready != 0) begin
            gq.push_back(req_ready[1] ? 1 : 0);
            aq.push_back(cyc);
            acc_cyc = cyc;
        end
        if (prev_busy && !busy) begin
            fq.push_back(cyc);
            fall_cyc = cyc;
        end
        prev_busy = busy;

        if (g >= 0) begin
            d = (!p_rs[g] && p_data[g] >= 8'h01 && p_data[g] <= 8'h03) ? int'(LONGD) : int'(CMDD);
            m_t     = cyc;
            m_tot   = 3 + 2 * int'(EN) + int'(GAP) + d;
            m_end   = cyc + m_tot;
            m_hi    = p_data[g][7:4];
            m_lo    = p_data[g][3:0];
            m_rsc   = p_rs[g];
            m_gidn  = 2'(g);
            m_ptr   = (g + 1) % int'(NREQ);
            m_owner = p_lock[g] ? g : -1;
            if (p_lock[g] && refill > 0 && refill < 100) keep[g] = $urandom_range(6);
            p_valid[g] = 1'b0;
        end
    endtask

    task automatic one_write(input string tag, input logic [9:0] item, input int lat);
        acc_cyc = -1000; fall_cyc = -1;
        q0.push_back(item);
        repeat (30) cycle(0);
        chk(tag, 32'(fall_cyc - acc_cyc), 32'(lat));
    endtask

    initial begin
        int gs, as, fs, o0;
        int rr_exp [4];
        int lk_exp [6];
        rr_exp = '{0, 1, 0, 1};
        lk_exp = '{1, 1, 1, 0, 1, 0};
        do_reset();

        one_write("lat_data55",  {1'b1, 1'b0, 8'h55}, 16);
        one_write("lat_clear",   {1'b0, 1'b0, 8'h01}, 23);
        one_write("lat_data01",  {1'b1, 1'b0, 8'h01}, 16);
        one_write("lat_cmd03",   {1'b0, 1'b0, 8'h03}, 23);
        one_write("lat_cmd04",   {1'b0, 1'b0, 8'h04}, 16);

        // Both requesters always valid: strict alternation.
        do_reset();
        gs = gq.size();
        repeat (70) cycle(100);
        for (int k = 0; k < 4; k++)
            chk("rr_order", 32'((gs + k < gq.size()) ? gq[gs + k] : 99), 32'(rr_exp[k]));

        // Locked burst from req1 while req0 waits, then release by dropping lock.
        do_reset();
        gs = gq.size();
        q1.push_back({1'b0, 1'b1, 8'h80});
        q1.push_back({1'b1, 1'b1, 8'h48});
        q1.push_back({1'b1, 1'b0, 8'h49});
        cycle(0);
        q0.push_back({1'b1, 1'b0, 8'h11});
        repeat (90) cycle(0);
        as = aq.size(); fs = fq.size();
        q1.push_back({1'b0, 1'b1, 8'h80});
        q0.push_back({1'b1, 1'b0, 8'h22});
        repeat (45) cycle(0);
        for (int k = 0; k < 6; k++)
            chk("lock_order", 32'((gs + k < gq.size()) ? gq[gs + k] : 99), 32'(lk_exp[k]));
        o0 = (as + 1 < aq.size() && fs < fq.size()) ? aq[as + 1] - fq[fs] : -1;
        chk("release_gap", 32'(o0), 1);

        // Random traffic with locks and lock holding.
        do_reset();
        repeat (1500) cycle(35);

        // Reset while the high nibble strobe is active.
        do_reset();
        q0.push_back({1'b1, 1'b0, 8'hA7});
        repeat (4) cycle(0);
        chk("pre_rst_en", lcd_en, 1);
        do_reset();
        one_write("lat_after_rst", {1'b1, 1'b0, 8'h3C}, 16);
        chk("after_rst_gid", grant_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
